// File: rtl/ascii_operand_parser.sv
// Parses "DD+DD=" ASCII expressions and latches the four operand digits for the ASCII adder.
// One- or two-digit operands; malformed streams abort with an error pulse and cause code.
module ascii_operand_parser #(
    parameter int unsigned       CHAR_W   = 7,
    parameter logic [CHAR_W-1:0] PLUS_CHR = 7'h2B,
    parameter logic [CHAR_W-1:0] EQ_CHR   = 7'h3D,
    parameter int unsigned       TIMEOUT  = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CHAR_W-1:0] in_char,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CHAR_W-1:0] AD,
    output logic [CHAR_W-1:0] AU,
    output logic [CHAR_W-1:0] BD,
    output logic [CHAR_W-1:0] BU,
    output logic              op_valid,
    input  logic              op_ack,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int unsigned       CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit                TO_EN    = (TIMEOUT > 0);
    localparam logic [CHAR_W-1:0] ZERO_CHR = CHAR_W'(48);
    localparam logic [CHAR_W-1:0] NINE_CHR = CHAR_W'(57);

    typedef enum logic [2:0] {StA0, StA1, StAop, StB0, StB1, StBeq, StHold} state_e;

    state_e            state;
    logic [CNT_W-1:0]  idle_cnt;
    logic [CHAR_W-1:0] a_d0, a_hi, a_lo, b_d0, b_hi, b_lo;
    logic              is_digit;
    logic              xfer;
    logic [1:0]        abort_code;

    assign is_digit = (in_char >= ZERO_CHR) && (in_char <= NINE_CHR);
    assign xfer     = in_valid && in_ready;

    // Cause of abort if the current character were accepted; 0 means the character is legal.
    always_comb begin
        abort_code = 2'd0;
        case (state)
            StA0, StB0: if (!is_digit) abort_code = 2'd1;
            StA1:       if (!is_digit && in_char != PLUS_CHR) abort_code = 2'd1;
            StAop:      if (is_digit) abort_code = 2'd2;
                        else if (in_char != PLUS_CHR) abort_code = 2'd1;
            StB1:       if (!is_digit && in_char != EQ_CHR) abort_code = 2'd1;
            StBeq:      if (is_digit) abort_code = 2'd2;
                        else if (in_char != EQ_CHR) abort_code = 2'd1;
            default:    abort_code = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StA0;
            idle_cnt <= '0;
            in_ready <= 1'b1;
            op_valid <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            AD       <= ZERO_CHR;
            AU       <= ZERO_CHR;
            BD       <= ZERO_CHR;
            BU       <= ZERO_CHR;
            a_d0     <= ZERO_CHR;
            a_hi     <= ZERO_CHR;
            a_lo     <= ZERO_CHR;
            b_d0     <= ZERO_CHR;
            b_hi     <= ZERO_CHR;
            b_lo     <= ZERO_CHR;
        end else begin
            err <= 1'b0;
            if (state == StHold) begin
                idle_cnt <= '0;
                if (op_ack) begin
                    op_valid <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= StA0;
                end
            end else if (xfer) begin
                idle_cnt <= '0;
                if (abort_code != 2'd0) begin
                    err      <= 1'b1;
                    err_code <= abort_code;
                    state    <= StA0;
                end else begin
                    unique case (state)
                        StA0: begin
                            a_d0  <= in_char;
                            state <= StA1;
                        end
                        StA1: begin
                            if (is_digit) begin
                                a_hi  <= a_d0;
                                a_lo  <= in_char;
                                state <= StAop;
                            end else begin
                                a_hi  <= ZERO_CHR;
                                a_lo  <= a_d0;
                                state <= StB0;
                            end
                        end
                        StAop: state <= StB0;
                        StB0: begin
                            b_d0  <= in_char;
                            state <= StB1;
                        end
                        StB1: begin
                            if (is_digit) begin
                                b_hi  <= b_d0;
                                b_lo  <= in_char;
                                state <= StBeq;
                            end else begin
                                // '=' after a single B digit: commit with an implied leading zero
                                b_hi     <= ZERO_CHR;
                                b_lo     <= b_d0;
                                AD       <= a_hi;
                                AU       <= a_lo;
                                BD       <= ZERO_CHR;
                                BU       <= b_d0;
                                op_valid <= 1'b1;
                                in_ready <= 1'b0;
                                state    <= StHold;
                            end
                        end
                        StBeq: begin
                            AD       <= a_hi;
                            AU       <= a_lo;
                            BD       <= b_hi;
                            BU       <= b_lo;
                            op_valid <= 1'b1;
                            in_ready <= 1'b0;
                            state    <= StHold;
                        end
                        default: state <= StA0;
                    endcase
                end
            end else if (state != StA0) begin
                // Idle mid-expression: abort on the edge where the count reaches TIMEOUT
                if (TO_EN && idle_cnt == CNT_LAST) begin
                    idle_cnt <= '0;
                    err      <= 1'b1;
                    err_code <= 2'd3;
                    state    <= StA0;
                end else if (idle_cnt != {CNT_W{1'b1}}) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ascii_operand_parser.sv
// Self-checking bench for ascii_operand_parser: table vectors, corner sequences and a
// randomized run checked cycle by cycle against a digit-count/arithmetic reference model.
module tb_ascii_operand_parser;

    localparam int unsigned TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] in_char;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] AD, AU, BD, BU;
    logic       op_valid;
    logic       op_ack;
    logic       err;
    logic [1:0] err_code;

    int n_cmp = 0;
    int n_bad = 0;

    ascii_operand_parser #(
        .CHAR_W  (7),
        .PLUS_CHR(7'h2B),
        .EQ_CHR  (7'h3D),
        .TIMEOUT (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_char (in_char),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .AD      (AD),
        .AU      (AU),
        .BD      (BD),
        .BU      (BU),
        .op_valid(op_valid),
        .op_ack  (op_ack),
        .err     (err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Reference model: expression progress tracked as digit counts and integer operand values
    logic [6:0] m_ad, m_au, m_bd, m_bu;
    bit         m_hold, m_err;
    logic [1:0] m_code;
    int         phase, na, nb, aval, bval, idle;

    task automatic parse_clear();
        phase = 0; na = 0; nb = 0; aval = 0; bval = 0; idle = 0;
    endtask

    task automatic model_reset();
        m_ad = 7'h30; m_au = 7'h30; m_bd = 7'h30; m_bu = 7'h30;
        m_hold = 0; m_err = 0; m_code = 2'd0;
        parse_clear();
    endtask

    task automatic model_abort(input logic [1:0] code);
        m_err  = 1;
        m_code = code;
        parse_clear();
    endtask

    task automatic model_edge(input bit v, input logic [6:0] c, input bit ack);
        bit is_d;
        int dv;
        m_err = 0;
        is_d  = (c >= 7'h30) && (c <= 7'h39);
        dv    = int'(c) - 48;
        if (m_hold) begin
            if (ack) m_hold = 0;
        end else if (v) begin
            idle = 0;
            if (phase == 0) begin
                if (is_d) begin
                    if (na == 2) model_abort(2'd2);
                    else begin aval = aval * 10 + dv; na++; end
                end else if (c == 7'h2B && na > 0) phase = 1;
                else model_abort(2'd1);
            end else begin
                if (is_d) begin
                    if (nb == 2) model_abort(2'd2);
                    else begin bval = bval * 10 + dv; nb++; end
                end else if (c == 7'h3D && nb > 0) begin
                    m_ad = 7'(48 + aval / 10);
                    m_au = 7'(48 + aval % 10);
                    m_bd = 7'(48 + bval / 10);
                    m_bu = 7'(48 + bval % 10);
                    m_hold = 1;
                    parse_clear();
                end else model_abort(2'd1);
            end
        end else if (phase != 0 || na != 0) begin
            idle++;
            if (idle == TO) model_abort(2'd3);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit v, input logic [6:0] c, input bit ack);
        in_valid = v;
        in_char  = c;
        op_ack   = ack;
        @(posedge clk);
        model_edge(v, c, ack);
        #1;
        check("cycle", {31'd0, in_ready, op_valid, err, err_code, AD, AU, BD, BU},
              {31'd0, ~m_hold, m_hold, m_err, m_code, m_ad, m_au, m_bd, m_bu});
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte b;
            b = s[i];
            step(1'b1, b[6:0], 1'b0);
        end
    endtask

    task automatic check_digits(input string name, input logic [27:0] exp);
        check(name, {36'd0, AD, AU, BD, BU}, {36'd0, exp});
    endtask

    typedef struct {
        string      s;
        logic [6:0] ad, au, bd, bu;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{s: "47+85=", ad: 7'h34, au: 7'h37, bd: 7'h38, bu: 7'h35};
        tbl[1] = '{s: "7+9=",   ad: 7'h30, au: 7'h37, bd: 7'h30, bu: 7'h39};
        tbl[2] = '{s: "99+0=",  ad: 7'h39, au: 7'h39, bd: 7'h30, bu: 7'h30};
        tbl[3] = '{s: "05+10=", ad: 7'h30, au: 7'h35, bd: 7'h31, bu: 7'h30};
        tbl[4] = '{s: "3+62=",  ad: 7'h30, au: 7'h33, bd: 7'h36, bu: 7'h32};

        rst = 1'b1; in_valid = 1'b0; in_char = 7'h00; op_ack = 1'b0;
        model_reset();
        #12 rst = 1'b0;
        #1;
        check("reset_ctl", {60'd0, in_ready, op_valid, err, err_code != 2'd0}, {60'd0, 4'b1000});
        check_digits("reset_digits", {4{7'h30}});

        foreach (tbl[k]) begin
            send_str(tbl[k].s);
            check("tbl_op_valid", {63'd0, op_valid}, 64'd1);
            check_digits("tbl_digits", {tbl[k].ad, tbl[k].au, tbl[k].bd, tbl[k].bu});
            check("tbl_no_err", {63'd0, err}, 64'd0);
            step(1'b0, 7'h00, 1'b1);
            check("tbl_ack", {62'd0, op_valid, in_ready}, {62'd0, 2'b01});
        end

        // Three digits in A, then a good expression
        send_str("123");
        check("too_many_digits", {61'd0, err, err_code}, {61'd0, 3'b110});
        send_str("1+1=");
        check_digits("after_err2", {7'h30, 7'h31, 7'h30, 7'h31});
        check("after_err2_valid", {63'd0, op_valid}, 64'd1);
        step(1'b0, 7'h00, 1'b1);

        // Unexpected char leaves operands untouched
        send_str("4x");
        check("unexpected", {61'd0, err, err_code}, {61'd0, 3'b101});
        check_digits("unexpected_keep", {7'h30, 7'h31, 7'h30, 7'h31});

        // Timeout after TO idle cycles mid-expression
        send_str("4+");
        for (int i = 0; i < TO - 1; i++) step(1'b0, 7'h00, 1'b0);
        check("timeout_early", {63'd0, err}, 64'd0);
        step(1'b0, 7'h00, 1'b0);
        check("timeout", {61'd0, err, err_code}, {61'd0, 3'b111});
        step(1'b0, 7'h00, 1'b0);
        check("timeout_pulse", {61'd0, err, err_code}, {61'd0, 3'b011});

        // Backpressure during hold with a pending character
        send_str("12+34=");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 7'h35, 1'b0);
            check("hold_stall", {62'd0, in_ready, op_valid}, {62'd0, 2'b01});
        end
        step(1'b1, 7'h35, 1'b1);
        check("hold_release", {62'd0, in_ready, op_valid}, {62'd0, 2'b10});
        step(1'b1, 7'h35, 1'b0);
        send_str("+6=");
        check_digits("pending_consumed_once", {7'h30, 7'h35, 7'h30, 7'h36});
        step(1'b0, 7'h00, 1'b1);

        // Asynchronous reset mid-cycle, mid-expression
        send_str("12+3");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_ctl", {59'd0, in_ready, op_valid, err, err_code}, {59'd0, 5'b10000});
        check_digits("async_rst_digits", {4{7'h30}});
        rst = 1'b0;
        send_str("00+00=");
        check("zero_expr", {35'd0, op_valid, AD, AU, BD, BU}, {35'd0, 1'b1, {4{7'h30}}});
        step(1'b0, 7'h00, 1'b1);

        // Randomized run against the model
        begin
            int burst;
            burst = 0;
            for (int i = 0; i < 4000; i++) begin
                bit         v, a;
                logic [6:0] c;
                int         r;
                if (burst > 0) begin
                    burst--;
                    v = 1'b0;
                end else begin
                    if ($urandom_range(0, 29) == 0) burst = int'($urandom_range(3, 12));
                    v = ($urandom_range(0, 9) < 8);
                end
                r = int'($urandom_range(0, 99));
                if (r < 50)      c = 7'h30 + 7'($urandom_range(0, 9));
                else if (r < 75) c = 7'h2B;
                else if (r < 95) c = 7'h3D;
                else             c = 7'($urandom_range(0, 127));
                a = ($urandom_range(0, 2) == 0);
                step(v, c, a);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
